// File: rtl/mux_tree_pipe.sv
// -----------------------------------------------------------------------------
// mux_tree_pipe
//   N_IN:1 multiplexer built as a binary tree of 2:1 stages with every tree
//   level registered. Select bits are consumed LSB-first, one bit per level,
//   so the pipeline depth equals LEVELS = $clog2(N_IN).
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (assert async, release sync)
//   i_data   N_IN*WIDTH  channel k at i_data[k*WIDTH +: WIDTH]
//   i_sel    LEVELS      channel index to forward
//   i_valid  1           i_data/i_sel valid
//   i_ready  1           block accepts a word at this edge
//   o_data   WIDTH       selected channel data
//   o_sel    LEVELS      channel index that produced o_data
//   o_valid  1           o_data/o_sel valid
//   o_ready  1           downstream accepts o_data at this edge
//
// Handshake: a word moves across an interface on every rising edge where
// valid and ready are both high. valid never waits on ready, and once valid
// is raised the payload is held unchanged until the transfer happens.
// i_ready is a pure function of stage occupancy and o_ready; it never looks
// at i_valid. Each stage advances when the stage after it advances or when it
// holds no word (ready_s = ready_{s+1} | ~valid_s), so empty slots (bubbles)
// are squeezed out and all LEVELS registers can be filled during a stall.
// -----------------------------------------------------------------------------
module mux_tree_pipe #(
  parameter  int WIDTH  = 8,
  parameter  int N_IN   = 8,
  localparam int LEVELS = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN*WIDTH-1:0]  i_data,
  input  logic [LEVELS-1:0]      i_sel,
  input  logic                   i_valid,
  output logic                   i_ready,
  output logic [WIDTH-1:0]       o_data,
  output logic [LEVELS-1:0]      o_sel,
  output logic                   o_valid,
  input  logic                   o_ready
);

  // Stage 0 is the input port itself (combinational); stages 1..LEVELS are
  // registers. Stage s carries N_IN>>s words, the full original index (its
  // upper bits are the selects still to be consumed) and a valid flag.
  for (genvar s = 0; s <= LEVELS; s++) begin : g_stage
    localparam int NW = N_IN >> s;

    logic [NW*WIDTH-1:0] data;
    logic [LEVELS-1:0]   sel;
    logic                valid;
    logic                ready;

    if (s == 0) begin : g_src
      assign data  = i_data;
      assign sel   = i_sel;
      assign valid = i_valid;
      // The input port can load exactly when stage 1 can.
      assign ready = g_stage[1].ready;
    end else begin : g_lvl
      logic [NW*WIDTH-1:0] data_nxt;
      logic                pick_hi;

      // Level s resolves index bit s-1 of the word arriving from stage s-1.
      assign pick_hi = g_stage[s-1].sel[s-1];

      if (s == LEVELS) begin : g_last
        assign ready = o_ready | ~valid;
      end else begin : g_mid
        assign ready = g_stage[s+1].ready | ~valid;
      end

      always_comb begin
        data_nxt = '0;
        for (int j = 0; j < NW; j++) begin
          data_nxt[j*WIDTH +: WIDTH] = pick_hi
            ? g_stage[s-1].data[(2*j+1)*WIDTH +: WIDTH]
            : g_stage[s-1].data[(2*j)*WIDTH +: WIDTH];
        end
      end

      // Data is loaded on bubbles too; only valid qualifies it downstream.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data  <= '0;
          sel   <= '0;
          valid <= 1'b0;
        end else if (ready) begin
          data  <= data_nxt;
          sel   <= g_stage[s-1].sel;
          valid <= g_stage[s-1].valid;
        end
      end
    end
  end

  assign i_ready = g_stage[0].ready;
  assign o_data  = g_stage[LEVELS].data;
  assign o_sel   = g_stage[LEVELS].sel;
  assign o_valid = g_stage[LEVELS].valid;

endmodule
